// File: rtl/seven_segment_capture.sv
// Seven-segment display snooper: watches a multiplexed, active-low anode/segment
// bus, captures each digit once it has been stable for STABLE_CYCLES cycles, and
// publishes a full 8-digit frame with a valid/ready handshake.
module seven_segment_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  anode,
    input  logic [6:0]  segments,
    output logic [31:0] frame_digits,
    output logic [7:0]  frame_err,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        overrun
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       prev_anode;
    logic [6:0]       prev_segments;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       mask;
    logic [31:0]      work_digits;
    logic [7:0]       work_err;

    logic             same;
    logic             anode_valid;
    logic [2:0]       sel_idx;
    logic [3:0]       zeros;
    logic [CNT_W-1:0] cnt_next;
    logic             capture;
    logic             new_digit;
    logic [7:0]       mask_next;
    logic             complete;
    logic [3:0]       dec_nib;
    logic             dec_err;
    logic [31:0]      digits_ins;
    logic [7:0]       err_ins;

    // Active-low pattern to {error, nibble}; anything outside the table is an error.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'b0000001: decode = 5'h00;
            7'b1001111: decode = 5'h01;
            7'b0010010: decode = 5'h02;
            7'b0000110: decode = 5'h03;
            7'b1001100: decode = 5'h04;
            7'b0100100: decode = 5'h05;
            7'b0100000: decode = 5'h06;
            7'b0001111: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0000100: decode = 5'h09;
            7'b0001000: decode = 5'h0A;
            7'b1100000: decode = 5'h0B;
            7'b0110001: decode = 5'h0C;
            7'b1000010: decode = 5'h0D;
            7'b0110000: decode = 5'h0E;
            7'b0111000: decode = 5'h0F;
            default:    decode = 5'h10;
        endcase
    endfunction

    // Digit select, stability tracking and capture/frame-completion decisions.
    always_comb begin
        zeros   = 4'd0;
        sel_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!anode[i]) begin
                zeros   = zeros + 4'd1;
                sel_idx = 3'(i);
            end
        end
        anode_valid = (zeros == 4'd1);

        same = (anode == prev_anode) && (segments == prev_segments);
        if (!same)
            cnt_next = '0;
        else if (cnt == CNT_MAX)
            cnt_next = cnt;
        else
            cnt_next = cnt + CNT_W'(1);

        // Capture on the edge where the counter reaches its terminal value.
        capture   = (state == TRACK) && same && (cnt_next == CNT_MAX);
        new_digit = capture && !mask[sel_idx];
        mask_next = mask | (8'(1) << sel_idx);
        complete  = new_digit && (mask_next == 8'hFF);

        {dec_err, dec_nib} = decode(segments);
        digits_ins = work_digits;
        digits_ins[4*int'(sel_idx) +: 4] = dec_nib;
        err_ins = work_err;
        err_ins[sel_idx] = dec_err;
    end

    // State, working frame and published frame registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            prev_anode    <= 8'h00;
            prev_segments <= 7'h00;
            cnt           <= '0;
            mask          <= 8'h00;
            work_digits   <= 32'h0;
            work_err      <= 8'h00;
            frame_digits  <= 32'h0;
            frame_err     <= 8'h00;
            frame_valid   <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            prev_anode    <= anode;
            prev_segments <= segments;
            cnt           <= cnt_next;

            if (!same) begin
                state <= anode_valid ? TRACK : IDLE;
            end else begin
                case (state)
                    IDLE:    if (anode_valid) state <= TRACK;
                    TRACK:   if (capture) state <= HOLD;
                    HOLD:    state <= HOLD;
                    default: state <= IDLE;
                endcase
            end

            if (new_digit) begin
                work_digits <= digits_ins;
                work_err    <= err_ins;
                mask        <= complete ? 8'h00 : mask_next;
            end

            if (complete) begin
                if (!frame_valid || frame_ready) begin
                    frame_digits <= digits_ins;
                    frame_err    <= err_ins;
                    frame_valid  <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule
